// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the functional units and the CDB arbiter: per-FU result
// inputs with their ready flags, plus the registered CDB broadcast.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(NUM_FU)
);
    // Handshake: FU i's result transfers at the clock edge where fu_valid[i] and
    // fu_ready[i] are both high. fu_ready comes only from buffer occupancy, so an
    // FU may look at it before deciding to drive valid. Data offered while ready
    // is low is not taken. cdb_valid has no back-pressure: it is a one-cycle
    // broadcast.
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU*TAG_W-1:0]  fu_tag;
    logic [NUM_FU*DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0]        fu_ready;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [SRC_W-1:0]         cdb_src;

    modport master (
        output fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Per-FU result FIFOs feeding a round-robin arbiter that broadcasts one result per
// cycle on the CDB. Optional macro CDB_PERF_EN adds a saturating conflict counter.
module cdb_arbiter #(
    parameter int NUM_FU    = 5,
    parameter int TAG_W     = 3,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    cdb_arbiter_if.slave bus
`ifdef CDB_PERF_EN
    ,
    output logic [15:0]  perf_conflict_cnt
`endif
);
    localparam int SRC_W = $clog2(NUM_FU);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [SRC_W:0]   NUM_FU_X = (SRC_W + 1)'(NUM_FU);
    localparam logic [SRC_W-1:0] LAST_FU  = SRC_W'(NUM_FU - 1);

    logic [TAG_W-1:0]  tag_mem_q  [NUM_FU][BUF_DEPTH];
    logic [DATA_W-1:0] data_mem_q [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_FU], wr_ptr_d [NUM_FU];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_FU], rd_ptr_d [NUM_FU];
    logic [CNT_W-1:0]  cnt_q    [NUM_FU], cnt_d    [NUM_FU];
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic [NUM_FU-1:0]   req, ready, push, pop;
    logic [2*NUM_FU-1:0] req2;
    logic [NUM_FU-1:0]   req_rot;
    logic [SRC_W-1:0]    offset, grant_idx;
    logic [SRC_W:0]      win_sum;
    logic                grant_vld;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            ready[i] = (cnt_q[i] != FULL_CNT);
            req[i]   = (cnt_q[i] != '0);
            // Zero-tag results are acknowledged but never stored.
            push[i]  = bus.fu_valid[i] && ready[i] && (bus.fu_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner's offset.
    always_comb begin
        req2      = {req, req};
        req_rot   = req2[{1'b0, rr_ptr_q} +: NUM_FU];
        grant_vld = 1'b0;
        offset    = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_vld = 1'b1;
                offset    = SRC_W'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
        if (win_sum >= NUM_FU_X) begin
            win_sum = win_sum - NUM_FU_X;
        end
        grant_idx = win_sum[SRC_W-1:0];
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = grant_vld && (grant_idx == SRC_W'(i));
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        for (int i = 0; i < NUM_FU; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
        end
        if (flush) begin
            rr_ptr_d = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
                if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (grant_vld) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = tag_mem_q[grant_idx][rd_ptr_q[grant_idx]];
                cdb_data_d  = data_mem_q[grant_idx][rd_ptr_q[grant_idx]];
                cdb_src_d   = grant_idx;
                rr_ptr_d    = (grant_idx == LAST_FU) ? '0 : grant_idx + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // Storage needs no reset: an entry is only read after its count covers it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i] && !flush) begin
                tag_mem_q[i][wr_ptr_q[i]]  <= bus.fu_tag[i*TAG_W +: TAG_W];
                data_mem_q[i][wr_ptr_q[i]] <= bus.fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;

`ifdef CDB_PERF_EN
    logic [15:0] perf_q, perf_d;
    logic        multi_req;

    // Two or more requesters: clearing the lowest set bit still leaves one.
    always_comb begin
        multi_req = |(req & (req - NUM_FU'(1)));
        perf_d    = perf_q;
        if (multi_req && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflict_cnt = perf_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: randomized and directed stimulus compared
// each cycle against a queue-based reference model of the FIFOs and round-robin.
module tb_cdb_arbiter;
    localparam int NUM_FU    = 5;
    localparam int TAG_W     = 3;
    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 2;
    localparam int SRC_W     = 3;
    localparam int E_W       = TAG_W + DATA_W;
    localparam int CW        = 1 + SRC_W + TAG_W + DATA_W;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();
`ifdef CDB_PERF_EN
    logic [15:0] perf_conflict_cnt;
`endif

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus(bus)
`ifdef CDB_PERF_EN
        ,
        .perf_conflict_cnt(perf_conflict_cnt)
`endif
    );

    // Reference model: one queue of {tag,data} per FU plus the round-robin start.
    logic [E_W-1:0]    exp_q [NUM_FU][$];
    int                m_rr;
    logic              m_valid;
    logic [SRC_W-1:0]  m_src;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    int                m_perf;

    int errors = 0;
    int checks = 0;

    function automatic logic [CW-1:0] m_cdb();
        return {m_valid, m_src, m_tag, m_data};
    endfunction

    function automatic logic [CW-1:0] obs_cdb();
        return {bus.cdb_valid, bus.cdb_src, bus.cdb_tag, bus.cdb_data};
    endfunction

    function automatic logic [NUM_FU-1:0] m_ready();
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) r[i] = (exp_q[i].size() != BUF_DEPTH);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) exp_q[i].delete();
        m_rr = 0; m_valid = 1'b0; m_src = '0; m_tag = '0; m_data = '0; m_perf = 0;
    endtask

    task automatic drive_idle();
        flush = 1'b0;
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_data  = '0;
    endtask

    task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bus.fu_valid[i] = 1'b1;
        bus.fu_tag[i*TAG_W +: TAG_W]    = t;
        bus.fu_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic step();
        logic [NUM_FU-1:0] rdy;
        logic [E_W-1:0]    e;
        int                nonempty;
        int                win;
        rdy = m_ready();
        nonempty = 0;
        for (int i = 0; i < NUM_FU; i++) if (exp_q[i].size() != 0) nonempty++;
        if (nonempty >= 2 && m_perf < 65535) m_perf++;
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) exp_q[i].delete();
            m_valid = 1'b0;
            m_rr    = 0;
        end else begin
            win = -1;
            for (int k = 0; k < NUM_FU; k++) begin
                if (win < 0 && exp_q[(m_rr + k) % NUM_FU].size() != 0) win = (m_rr + k) % NUM_FU;
            end
            if (win >= 0) begin
                e       = exp_q[win].pop_front();
                m_valid = 1'b1;
                m_tag   = e[E_W-1:DATA_W];
                m_data  = e[DATA_W-1:0];
                m_src   = SRC_W'(win);
                m_rr    = (win + 1) % NUM_FU;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (bus.fu_valid[i] && rdy[i] && bus.fu_tag[i*TAG_W +: TAG_W] != '0)
                    exp_q[i].push_back({bus.fu_tag[i*TAG_W +: TAG_W], bus.fu_data[i*DATA_W +: DATA_W]});
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_idle();
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        model_reset();
        #1;
        checks++;
        if (obs_cdb() !== '0) begin
            errors++; $display("FAIL reset_cdb: got %h expected 0", obs_cdb());
        end
        checks++;
        if (bus.fu_ready !== '1) begin
            errors++; $display("FAIL reset_ready: got %b expected 11111", bus.fu_ready);
        end
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 3'd1, 32'h1234_0000 + i);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_idle();
        checks++;
        if (bus.fu_ready !== '1) begin
            errors++; $display("FAIL reset_ignores_valid: got %b expected 11111", bus.fu_ready);
        end
        step();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_broadcast: got %b expected 0", bus.cdb_valid);
        end
    endtask

    task automatic test_single();
        apply_reset();
        set_fu(2, 3'd3, 32'hDEAD_BEEF);
        step();
        drive_idle();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++; $display("FAIL single_no_bypass: got %b expected 0", bus.cdb_valid);
        end
        step();
        checks++;
        if (obs_cdb() !== {1'b1, 3'd2, 3'd3, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL single_broadcast: got %h expected %h", obs_cdb(), {1'b1, 3'd2, 3'd3, 32'hDEAD_BEEF});
        end
        step();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++; $display("FAIL single_one_cycle: got %b expected 0", bus.cdb_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [SRC_W-1:0] want_src [3];
        logic [TAG_W-1:0] want_tag [3];
        want_src[0] = 3'd0; want_src[1] = 3'd1; want_src[2] = 3'd4;
        want_tag[0] = 3'd1; want_tag[1] = 3'd2; want_tag[2] = 3'd5;
        apply_reset();
        set_fu(0, 3'd1, $urandom);
        set_fu(1, 3'd2, $urandom);
        set_fu(4, 3'd5, $urandom);
        step();
        drive_idle();
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if ({bus.cdb_valid, bus.cdb_src, bus.cdb_tag} !== {1'b1, want_src[n], want_tag[n]}) begin
                errors++; $display("FAIL rr_order[%0d]: got %h expected %h", n,
                                   {bus.cdb_valid, bus.cdb_src, bus.cdb_tag}, {1'b1, want_src[n], want_tag[n]});
            end
            checks++;
            if (obs_cdb() !== m_cdb()) begin
                errors++; $display("FAIL rr_model[%0d]: got %h expected %h", n, obs_cdb(), m_cdb());
            end
        end
        step();
        checks++;
        if (bus.cdb_valid !== 1'b0) begin
            errors++; $display("FAIL rr_idle: got %b expected 0", bus.cdb_valid);
        end
        // Pointer wrapped to 0 after FU4, so FU0 beats FU4 next.
        set_fu(0, 3'd6, $urandom);
        set_fu(4, 3'd7, $urandom);
        step();
        drive_idle();
        step();
        checks++;
        if ({bus.cdb_valid, bus.cdb_src} !== {1'b1, 3'd0}) begin
            errors++; $display("FAIL rr_wrap: got %h expected %h", {bus.cdb_valid, bus.cdb_src}, {1'b1, 3'd0});
        end
        step();
        step();
    endtask

    task automatic test_backpressure();
        logic [E_W-1:0] items [3];
        logic [E_W-1:0] fu1_seen [$];
        logic [NUM_FU-1:0] rdy;
        int n;
        apply_reset();
        for (int j = 0; j < 3; j++) items[j] = {TAG_W'(j + 5), 32'($urandom)};
        n = 0;
        for (int c = 0; c < 30; c++) begin
            drive_idle();
            if (c < 14) begin
                set_fu(0, TAG_W'($urandom_range(1, 7)), $urandom);
                set_fu(2, TAG_W'($urandom_range(1, 7)), $urandom);
            end
            if (n < 3) set_fu(1, items[n][E_W-1:DATA_W], items[n][DATA_W-1:0]);
            rdy = m_ready();
            checks++;
            if (bus.fu_ready !== rdy) begin
                errors++; $display("FAIL bp_ready c%0d: got %b expected %b", c, bus.fu_ready, rdy);
            end
            step();
            if (n < 3 && rdy[1]) n++;
            if (bus.cdb_valid === 1'b1 && bus.cdb_src === 3'd1) fu1_seen.push_back({bus.cdb_tag, bus.cdb_data});
            checks++;
            if (obs_cdb() !== m_cdb()) begin
                errors++; $display("FAIL bp_cdb c%0d: got %h expected %h", c, obs_cdb(), m_cdb());
            end
        end
        drive_idle();
        checks++;
        if (fu1_seen.size() !== 3) begin
            errors++; $display("FAIL bp_fu1_count: got %0d expected 3", fu1_seen.size());
        end
        for (int j = 0; j < 3 && j < fu1_seen.size(); j++) begin
            checks++;
            if (fu1_seen[j] !== items[j]) begin
                errors++; $display("FAIL bp_fu1_order[%0d]: got %h expected %h", j, fu1_seen[j], items[j]);
            end
        end
    endtask

    task automatic test_zero_tag();
        apply_reset();
        set_fu(3, 3'd0, 32'h55);
        checks++;
        if (bus.fu_ready[3] !== 1'b1) begin
            errors++; $display("FAIL zero_ready_before: got %b expected 1", bus.fu_ready[3]);
        end
        step();
        drive_idle();
        checks++;
        if (bus.fu_ready !== '1) begin
            errors++; $display("FAIL zero_ready_after: got %b expected 11111", bus.fu_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.cdb_valid !== 1'b0) begin
                errors++; $display("FAIL zero_no_broadcast c%0d: got %b expected 0", c, bus.cdb_valid);
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 4; i++) set_fu(i, TAG_W'(i + 1), $urandom);
        step();
        drive_idle();
        flush = 1'b1;
        set_fu(0, 3'd6, 32'hF00D);
        step();
        drive_idle();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.cdb_valid !== 1'b0) begin
                errors++; $display("FAIL flush_no_broadcast c%0d: got %b expected 0", c, bus.cdb_valid);
            end
            checks++;
            if (bus.fu_ready !== '1) begin
                errors++; $display("FAIL flush_ready c%0d: got %b expected 11111", c, bus.fu_ready);
            end
            step();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            for (int i = 0; i < NUM_FU; i++) begin
                if ($urandom_range(0, 2) != 0) set_fu(i, TAG_W'($urandom_range(0, 7)), $urandom);
            end
            flush = ($urandom_range(0, 31) == 0);
            checks++;
            if (bus.fu_ready !== m_ready()) begin
                errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.fu_ready, m_ready());
            end
            step();
            checks++;
            if (obs_cdb() !== m_cdb()) begin
                errors++; $display("FAIL rand_cdb c%0d: got %h expected %h", c, obs_cdb(), m_cdb());
            end
`ifdef CDB_PERF_EN
            checks++;
            if (perf_conflict_cnt !== 16'(m_perf)) begin
                errors++; $display("FAIL rand_perf c%0d: got %0d expected %0d", c, perf_conflict_cnt, m_perf);
            end
`endif
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_fu(0, 3'd7, 32'hA5A5_5A5A);
        set_fu(1, 3'd4, 32'h0BAD_CAFE);
        step();
        drive_idle();
        step();
        checks++;
        if (obs_cdb() !== {1'b1, 3'd0, 3'd7, 32'hA5A5_5A5A}) begin
            errors++; $display("FAIL areset_pre: got %h expected %h", obs_cdb(), {1'b1, 3'd0, 3'd7, 32'hA5A5_5A5A});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_cdb() !== '0) begin
            errors++; $display("FAIL areset_immediate: got %h expected 0", obs_cdb());
        end
`ifdef CDB_PERF_EN
        checks++;
        if (perf_conflict_cnt !== 16'd0) begin
            errors++; $display("FAIL areset_perf: got %0d expected 0", perf_conflict_cnt);
        end
`endif
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.cdb_valid !== 1'b0) begin
                errors++; $display("FAIL areset_lost c%0d: got %b expected 0", c, bus.cdb_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_zero_tag();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
